sprite_mem_arbiter: RTL and testbench

- Shares one single-read-port sprite Memory between NUM_REQ pixel requesters: frog lookup plus car lanes.
- Sits between the sprite-display datapath address generators and the Memory instance.
- Grants one read per cycle with round-robin fairness.
- Returns read data tagged one-hot to the requester that issued it, after a fixed latency.

---
 rtl/sprite_arb_pkg.sv | 19 +
 rtl/sprite_rr_picker.sv | 33 +++
 rtl/sprite_mem_arbiter.sv | 91 +++++++++
 tb/tb_sprite_mem_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sprite_arb_pkg.sv
// rtl/sprite_arb_pkg.sv - shared constants and helpers for the sprite memory arbiter
package sprite_arb_pkg;

  localparam int SPRITE_ADDR_WIDTH = 10;
  localparam int SPRITE_DATA_WIDTH = 9;
  localparam logic [SPRITE_DATA_WIDTH-1:0] SPRITE_TRANSPARENT = 9'b111101110;
  localparam int TILE_SIZE = 32;

  // Index of the set bit; callers guarantee at most one bit is set.
  function automatic int onehot_to_index(input logic [7:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_rr_picker.sv
// rtl/sprite_rr_picker.sv - combinational rotate-priority encoder starting after the last winner
module sprite_rr_picker
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_grant
);

  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    any_grant = found;
  end

  assign win_idx = IDX_W'(onehot_to_index(8'(gnt)));

endmodule

// File: rtl/sprite_mem_arbiter.sv
// rtl/sprite_mem_arbiter.sv - round-robin arbiter sharing one sprite memory read port (optional SPRITE_ARB_CONFLICT_CNT_EN)
module sprite_mem_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = SPRITE_ADDR_WIDTH,
  parameter int DATA_WIDTH  = SPRITE_DATA_WIDTH,
  parameter int MEM_LATENCY = 1
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
`ifdef SPRITE_ARB_CONFLICT_CNT_EN
  input  logic                          i_Frame_Start,
  output logic [15:0]                   o_Conflict_Cnt,
`endif
  input  logic [NUM_REQ-1:0]            i_Req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_Addr,
  output logic [NUM_REQ-1:0]            o_Gnt,
  output logic [ADDR_WIDTH-1:0]         o_Mem_Addr,
  output logic                          o_Mem_Rd_En,
  input  logic [DATA_WIDTH-1:0]         i_Mem_Data,
  output logic [DATA_WIDTH-1:0]         o_Rd_Data,
  output logic [NUM_REQ-1:0]            o_Rd_Valid
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   win_idx;
  logic               any_grant;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] r_tag [MEM_LATENCY];

  sprite_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req       (i_Req),
    .last      (r_last),
    .gnt       (gnt),
    .win_idx   (win_idx),
    .any_grant (any_grant)
  );

  assign o_Gnt = gnt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_last      <= IDX_W'(NUM_REQ - 1);
      o_Mem_Addr  <= '0;
      o_Mem_Rd_En <= 1'b0;
    end else begin
      o_Mem_Rd_En <= any_grant;
      if (any_grant) begin
        r_last     <= win_idx;
        o_Mem_Addr <= i_Addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Owner tags ride alongside the memory read so data returns to its issuer.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < MEM_LATENCY; i++) r_tag[i] <= '0;
      o_Rd_Valid <= '0;
      o_Rd_Data  <= '0;
    end else begin
      r_tag[0] <= gnt;
      for (int i = 1; i < MEM_LATENCY; i++) r_tag[i] <= r_tag[i-1];
      if (|r_tag[MEM_LATENCY-1]) begin
        o_Rd_Valid <= r_tag[MEM_LATENCY-1];
        o_Rd_Data  <= i_Mem_Data;
      end else begin
        o_Rd_Valid <= '0;
      end
    end
  end

`ifdef SPRITE_ARB_CONFLICT_CNT_EN
  logic multi_req;
  assign multi_req = |(i_Req & (i_Req - NUM_REQ'(1)));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Conflict_Cnt <= '0;
    end else if (i_Frame_Start) begin
      o_Conflict_Cnt <= '0;
    end else if (multi_req && o_Conflict_Cnt != 16'hFFFF) begin
      o_Conflict_Cnt <= o_Conflict_Cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// tb/tb_sprite_mem_arbiter.sv - scoreboard bench for sprite_mem_arbiter
module tb_sprite_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i_Req;
  logic [39:0] i_Addr;
  logic [3:0]  o_Gnt;
  logic [9:0]  o_Mem_Addr;
  logic        o_Mem_Rd_En;
  logic [8:0]  i_Mem_Data;
  logic [8:0]  o_Rd_Data;
  logic [3:0]  o_Rd_Valid;
`ifdef SPRITE_ARB_CONFLICT_CNT_EN
  logic        frame_start;
  logic [15:0] conflict_cnt;
  int          exp_cnt;
`endif

  typedef struct {
    int         due;
    logic [3:0] tag;
    logic [8:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks;
  int         failures;
  int         cyc;
  int         ptr;
  logic [8:0] last_data;

  sprite_mem_arbiter dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
`ifdef SPRITE_ARB_CONFLICT_CNT_EN
    .i_Frame_Start  (frame_start),
    .o_Conflict_Cnt (conflict_cnt),
`endif
    .i_Req          (i_Req),
    .i_Addr         (i_Addr),
    .o_Gnt          (o_Gnt),
    .o_Mem_Addr     (o_Mem_Addr),
    .o_Mem_Rd_En    (o_Mem_Rd_En),
    .i_Mem_Data     (i_Mem_Data),
    .o_Rd_Data      (o_Rd_Data),
    .o_Rd_Valid     (o_Rd_Valid)
  );

  function automatic logic [8:0] mem_f(input logic [9:0] a);
    return 9'((a * 7) + 3);
  endfunction

  // Memory with one cycle of latency counted from the arbiter's address register.
  assign i_Mem_Data = mem_f(o_Mem_Addr);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] req, input logic [39:0] addrs);
    int         w;
    int         idx;
    logic [3:0] eg;
    logic [9:0] ea;
    logic       en;
    exp_t       e;
    @(negedge clk);
    i_Req  = req;
    i_Addr = addrs;
    #1;
    w = -1;
    for (int i = 1; i <= 4; i++) begin
      idx = (ptr + i) % 4;
      if (w < 0 && req[idx]) w = idx;
    end
    eg = (w < 0) ? 4'b0000 : (4'b0001 << w);
    chk("gnt", o_Gnt, eg);
    en = (w >= 0);
    ea = 10'd0;
    if (en) begin
      ea = addrs[w*10 +: 10];
      ptr = w;
      sb.push_back('{due: cyc + 2, tag: eg, data: mem_f(ea)});
    end
`ifdef SPRITE_ARB_CONFLICT_CNT_EN
    if (frame_start) exp_cnt = 0;
    else if ($countones(req) >= 2 && exp_cnt < 16'hFFFF) exp_cnt++;
`endif
    @(posedge clk);
    cyc++;
    #1;
    chk("mem_rd_en", o_Mem_Rd_En, en);
    if (en) chk("mem_addr", o_Mem_Addr, ea);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rd_valid", o_Rd_Valid, e.tag);
      chk("rd_data", o_Rd_Data, e.data);
      last_data = e.data;
    end else begin
      chk("rd_valid_idle", o_Rd_Valid, 4'b0000);
      chk("rd_data_hold", o_Rd_Data, last_data);
    end
  endtask

  initial begin
    clk = 0; rst_n = 0; i_Req = 0; i_Addr = 0;
    checks = 0; failures = 0; cyc = 0; ptr = 3; last_data = 0;
`ifdef SPRITE_ARB_CONFLICT_CNT_EN
    frame_start = 0; exp_cnt = 0;
`endif
    #12;
    chk("rst_rd_en", o_Mem_Rd_En, 1'b0);
    chk("rst_mem_addr", o_Mem_Addr, 10'd0);
    chk("rst_rd_valid", o_Rd_Valid, 4'b0000);
    chk("rst_rd_data", o_Rd_Data, 9'd0);
    chk("rst_gnt", o_Gnt, 4'b0000);
    @(negedge clk);
    rst_n = 1;

    step(4'b0001, {10'd0, 10'd0, 10'd0, 10'd37});
    repeat (2) step(4'b0000, 40'd0);

    step(4'b0010, {10'd4, 10'd3, 10'd2, 10'd1});
    step(4'b0011, {10'd4, 10'd3, 10'd100, 10'd200});
    step(4'b0011, {10'd4, 10'd3, 10'd101, 10'd201});
    repeat (5) step(4'b0000, 40'd0);

    step(4'b1111, {10'd44, 10'd33, 10'd22, 10'd11});
    step(4'b1111, {10'd45, 10'd34, 10'd23, 10'd12});
    @(negedge clk);
    i_Req = 4'b1111;
    rst_n = 0;
    #1;
    chk("mid_rst_rd_en", o_Mem_Rd_En, 1'b0);
    chk("mid_rst_mem_addr", o_Mem_Addr, 10'd0);
    chk("mid_rst_rd_valid", o_Rd_Valid, 4'b0000);
    chk("mid_rst_rd_data", o_Rd_Data, 9'd0);
    sb.delete();
    ptr = 3;
    last_data = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1;
    i_Req = 4'b0000;
`ifdef SPRITE_ARB_CONFLICT_CNT_EN
    exp_cnt = 0;
`endif
    repeat (3) step(4'b0000, 40'd0);

    repeat (8) step(4'b1111, {10'd40, 10'd30, 10'd20, 10'd10});
    repeat (3) step(4'b0000, 40'd0);

    step(4'b0100, {10'd0, 10'd555, 10'd0, 10'd0});
    step(4'b0100, {10'd0, 10'd556, 10'd0, 10'd0});
    step(4'b0100, {10'd0, 10'd557, 10'd0, 10'd0});
    repeat (3) step(4'b0000, 40'd0);

`ifdef SPRITE_ARB_CONFLICT_CNT_EN
    @(negedge clk);
    frame_start = 1;
    step(4'b0000, 40'd0);
    frame_start = 0;
    repeat (3) step(4'b0110, {10'd0, 10'd7, 10'd8, 10'd0});
    repeat (2) step(4'b0100, {10'd0, 10'd9, 10'd0, 10'd0});
    chk("conflict_cnt", conflict_cnt, 16'd3);
    chk("conflict_model", conflict_cnt, 32'(exp_cnt));
    frame_start = 1;
    step(4'b0110, {10'd0, 10'd7, 10'd8, 10'd0});
    frame_start = 0;
    chk("conflict_clr", conflict_cnt, 16'd0);
    repeat (3) step(4'b0000, 40'd0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
